// File: rtl/ps2_move_decoder.sv
// PS/2 scan-code set 2 decoder: turns make/break/extended byte sequences into move and command strobes.
// Optional auto-repeat of the most recent held direction is built when AUTOREPEAT_EN is defined.
module ps2_move_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 500000,
    parameter int unsigned ACCEPT_WASD    = 1,
    parameter int unsigned REPEAT_DELAY   = 25000000,
    parameter int unsigned REPEAT_PERIOD  = 5000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       ps2_key_pressed,
    input  logic [7:0] ps2_key_data,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic       enter_pulse,
    output logic       esc_pulse,
    output logic [3:0] held,
    output logic       seq_error
);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t      state;
    logic [19:0] timer;

    logic       ext;
    logic       is_prefix;
    logic       do_make;
    logic       do_break;
    logic       dir_hit;
    logic [1:0] dir_code;
    logic       enter_hit;
    logic       esc_hit;

    always_comb begin
        ext       = (state == EXT) || (state == EXT_BRK);
        is_prefix = (ps2_key_data == 8'hE0) || (ps2_key_data == 8'hF0);
        do_make   = ps2_key_pressed && !is_prefix && ((state == IDLE) || (state == EXT));
        do_break  = ps2_key_pressed && !is_prefix && ((state == BRK) || (state == EXT_BRK));
        dir_hit   = 1'b0;
        dir_code  = '0;
        if (ext) begin
            case (ps2_key_data)
                8'h75:   begin dir_hit = 1'b1; dir_code = 2'b00; end
                8'h72:   begin dir_hit = 1'b1; dir_code = 2'b01; end
                8'h6B:   begin dir_hit = 1'b1; dir_code = 2'b10; end
                8'h74:   begin dir_hit = 1'b1; dir_code = 2'b11; end
                default: ;
            endcase
        end else if (ACCEPT_WASD != 0) begin
            case (ps2_key_data)
                8'h1D:   begin dir_hit = 1'b1; dir_code = 2'b00; end
                8'h1B:   begin dir_hit = 1'b1; dir_code = 2'b01; end
                8'h1C:   begin dir_hit = 1'b1; dir_code = 2'b10; end
                8'h23:   begin dir_hit = 1'b1; dir_code = 2'b11; end
                default: ;
            endcase
        end
        // Keypad Enter (E0 5A) counts as Enter; Esc only exists as a plain code.
        enter_hit = (ps2_key_data == 8'h5A);
        esc_hit   = !ext && (ps2_key_data == 8'h76);
    end

`ifdef AUTOREPEAT_EN
    logic [1:0]  last_dir;
    logic [31:0] rep_cnt;
    logic        rep_first;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            move_valid  <= 1'b0;
            move_dir    <= '0;
            enter_pulse <= 1'b0;
            esc_pulse   <= 1'b0;
            held        <= '0;
            seq_error   <= 1'b0;
`ifdef AUTOREPEAT_EN
            last_dir    <= '0;
            rep_cnt     <= '0;
            rep_first   <= 1'b1;
`endif
        end else begin
            move_valid  <= 1'b0;
            enter_pulse <= 1'b0;
            esc_pulse   <= 1'b0;
            seq_error   <= 1'b0;

`ifdef AUTOREPEAT_EN
            // Repeat first; a decoded move below overrides it and restarts the delay.
            if (held[last_dir]) begin
                if (rep_cnt == (rep_first ? 32'(REPEAT_DELAY - 1) : 32'(REPEAT_PERIOD - 1))) begin
                    move_valid <= 1'b1;
                    move_dir   <= last_dir;
                    rep_cnt    <= '0;
                    rep_first  <= 1'b0;
                end else begin
                    rep_cnt <= rep_cnt + 32'd1;
                end
            end
`endif

            if (ps2_key_pressed) begin
                timer <= '0;
                case (state)
                    IDLE: begin
                        if (ps2_key_data == 8'hE0)      state <= EXT;
                        else if (ps2_key_data == 8'hF0) state <= BRK;
                    end
                    EXT: begin
                        if (ps2_key_data == 8'hF0) begin
                            state <= EXT_BRK;
                        end else if (ps2_key_data == 8'hE0) begin
                            state     <= EXT;
                            seq_error <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    BRK: begin
                        if (ps2_key_data == 8'hE0) begin
                            state     <= EXT;
                            seq_error <= 1'b1;
                        end else if (ps2_key_data == 8'hF0) begin
                            state     <= BRK;
                            seq_error <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        if (is_prefix) seq_error <= 1'b1;
                        state <= IDLE;
                    end
                endcase
            end else if (state != IDLE) begin
                if (timer == 20'(TIMEOUT_CYCLES - 1)) begin
                    state     <= IDLE;
                    seq_error <= 1'b1;
                    timer     <= '0;
                end else begin
                    timer <= timer + 20'd1;
                end
            end

            if (do_make) begin
                if (dir_hit && !held[dir_code]) begin
                    held[dir_code] <= 1'b1;
                    move_valid     <= 1'b1;
                    move_dir       <= dir_code;
`ifdef AUTOREPEAT_EN
                    last_dir  <= dir_code;
                    rep_cnt   <= '0;
                    rep_first <= 1'b1;
`endif
                end
                if (enter_hit) enter_pulse <= 1'b1;
                if (esc_hit)   esc_pulse   <= 1'b1;
            end

            if (do_break && dir_hit) begin
                held[dir_code] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Directed bench for ps2_move_decoder; a second instance with ACCEPT_WASD=0 checks the arrow-only map.
// The auto-repeat section is compiled in when AUTOREPEAT_EN is defined.
module tb_ps2_move_decoder;

    localparam int unsigned TMO = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pressed = 1'b0;
    logic [7:0] data = '0;

    logic       move_valid, enter_pulse, esc_pulse, seq_error;
    logic [1:0] move_dir;
    logic [3:0] held;
    logic       move_valid2, enter_pulse2, esc_pulse2, seq_error2;
    logic [1:0] move_dir2;
    logic [3:0] held2;

    int checks = 0;
    int fails  = 0;
    int n;

    always #5 clk = ~clk;

    ps2_move_decoder #(
        .TIMEOUT_CYCLES(TMO),
        .ACCEPT_WASD   (1),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (4)
    ) dut (
        .CLOCK_50       (clk),
        .reset          (reset),
        .ps2_key_pressed(pressed),
        .ps2_key_data   (data),
        .move_valid     (move_valid),
        .move_dir       (move_dir),
        .enter_pulse    (enter_pulse),
        .esc_pulse      (esc_pulse),
        .held           (held),
        .seq_error      (seq_error)
    );

    ps2_move_decoder #(
        .TIMEOUT_CYCLES(TMO),
        .ACCEPT_WASD   (0),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (4)
    ) dut_arrow (
        .CLOCK_50       (clk),
        .reset          (reset),
        .ps2_key_pressed(pressed),
        .ps2_key_data   (data),
        .move_valid     (move_valid2),
        .move_dir       (move_dir2),
        .enter_pulse    (enter_pulse2),
        .esc_pulse      (esc_pulse2),
        .held           (held2),
        .seq_error      (seq_error2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns at the falling edge after the byte was consumed, when its strobes are visible.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        pressed = 1'b1;
        data    = b;
        @(negedge clk);
        pressed = 1'b0;
    endtask

    task automatic wait_move(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!move_valid && cycles < 60);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_move_valid", move_valid, 0);
        chk("rst_move_dir", move_dir, 0);
        chk("rst_held", held, 0);
        chk("rst_enter", enter_pulse, 0);
        chk("rst_esc", esc_pulse, 0);
        chk("rst_seq_error", seq_error, 0);

        // Extended up make
        send(8'hE0);
        chk("e0_no_move", move_valid, 0);
        send(8'h75);
        chk("up_move", move_valid, 1);
        chk("up_dir", move_dir, 2'b00);
        chk("up_held", held, 4'b0001);
        chk("arrow_up_held", held2, 4'b0001);
        @(negedge clk);
        chk("up_one_cycle", move_valid, 0);

        // Typematic repeat then extended break
        send(8'hE0); send(8'h75);
        chk("typematic_no_move", move_valid, 0);
        chk("typematic_held", held, 4'b0001);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("up_break_no_move", move_valid, 0);
        chk("up_break_held", held, 4'b0000);

        // WASD alias, multiple held keys, shared held bit
        send(8'h1C);
        chk("a_move", move_valid, 1);
        chk("a_dir", move_dir, 2'b10);
        chk("a_held", held, 4'b0100);
        chk("arrow_a_no_move", move_valid2, 0);
        chk("arrow_a_held", held2, 4'b0000);
        send(8'hE0); send(8'h74);
        chk("right_move", move_valid, 1);
        chk("right_dir", move_dir, 2'b11);
        chk("right_held", held, 4'b1100);
        send(8'h23);
        chk("d_alias_no_move", move_valid, 0);
        send(8'hF0); send(8'h1C);
        chk("a_break_held", held, 4'b1000);
        send(8'hE0); send(8'hF0); send(8'h74);
        chk("right_break_held", held, 4'b0000);
        send(8'hF0); send(8'h1D);
        chk("nonheld_break_no_move", move_valid, 0);
        chk("nonheld_break_held", held, 4'b0000);

        // Prefix timeout leaves held alone
        send(8'h1D);
        chk("w_dir", move_dir, 2'b00);
        send(8'hE0);
        n = 0;
        while (!seq_error && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", n, TMO);
        chk("timeout_seq_error", seq_error, 1);
        chk("timeout_held", held, 4'b0001);
        send(8'h74);
        chk("plain74_no_move", move_valid, 0);
        chk("plain74_held", held, 4'b0001);
        send(8'hF0); send(8'h1D);
        chk("w_break_held", held, 4'b0000);

        // Illegal prefix order F0 E0 then extended make
        send(8'hF0); send(8'hE0);
        chk("f0e0_seq_error", seq_error, 1);
        send(8'h72);
        chk("f0e0_down_move", move_valid, 1);
        chk("f0e0_down_dir", move_dir, 2'b01);
        chk("f0e0_seq_error_clear", seq_error, 0);
        send(8'hE0); send(8'hF0); send(8'hE0);
        chk("e0f0e0_seq_error", seq_error, 1);
        send(8'hE0); send(8'hF0); send(8'h72);
        chk("down_break_held", held, 4'b0000);

        // Commands
        send(8'h5A);
        chk("enter_pulse", enter_pulse, 1);
        chk("enter_no_esc", esc_pulse, 0);
        send(8'h76);
        chk("esc_pulse", esc_pulse, 1);
        chk("esc_no_enter", enter_pulse, 0);
        send(8'hE0); send(8'h5A);
        chk("kp_enter_pulse", enter_pulse, 1);
        send(8'hE0); send(8'h76);
        chk("ext76_no_esc", esc_pulse, 0);

        // Reset mid-sequence discards the prefix
        send(8'h1D);
        send(8'hE0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("midreset_held", held, 4'b0000);
        send(8'h72);
        chk("midreset_no_move", move_valid, 0);
        chk("midreset_held_after", held, 4'b0000);

`ifdef AUTOREPEAT_EN
        send(8'hE0); send(8'h6B);
        chk("rep_t0_move", move_valid, 1);
        chk("rep_t0_dir", move_dir, 2'b10);
        wait_move(n);
        chk("rep_first_delay", n, 10);
        chk("rep_first_dir", move_dir, 2'b10);
        wait_move(n);
        chk("rep_period1", n, 4);
        wait_move(n);
        chk("rep_period2", n, 4);
        send(8'hE0); send(8'hF0); send(8'h6B);
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (move_valid) n++;
        end
        chk("rep_stopped", n, 0);
`else
        send(8'hE0); send(8'h6B);
        chk("hold_left_move", move_valid, 1);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (move_valid) n++;
        end
        chk("no_repeat", n, 0);
        chk("hold_left_held", held, 4'b0100);
        send(8'hE0); send(8'hF0); send(8'h6B);
        chk("left_break_held", held, 4'b0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
